// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Hazard-event inputs and pipeline stall/flush controls.
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead;
    logic [2:0]       IDEX_WR;
    logic [2:0]       IFID_Rs;
    logic [2:0]       IFID_Rt;
    logic             IFID_RsValid;
    logic             IFID_RtValid;
    logic             BranchTaken_EX;
    logic             Halt_EX;
    logic             IMemStall;
    logic             DMemStall;
    logic             PCWrite_En;
    logic             IFID_En;
    logic             IFID_Flush;
    logic             IDEX_En;
    logic             IDEX_Flush;
    logic             EXMEM_En;
    logic             MEMWB_En;
    logic             MEMWB_Bubble;
    logic             Halted;
    logic [CNT_W-1:0] StallCnt;

    // Pipeline side: raises events, consumes the controls.
    modport master (
        output IDEX_MemRead, IDEX_WR, IFID_Rs, IFID_Rt, IFID_RsValid, IFID_RtValid,
               BranchTaken_EX, Halt_EX, IMemStall, DMemStall,
        input  PCWrite_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush,
               EXMEM_En, MEMWB_En, MEMWB_Bubble, Halted, StallCnt
    );

    // Sequencer side.
    modport slave (
        input  IDEX_MemRead, IDEX_WR, IFID_Rs, IFID_Rt, IFID_RsValid, IFID_RtValid,
               BranchTaken_EX, Halt_EX, IMemStall, DMemStall,
        output PCWrite_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush,
               EXMEM_En, MEMWB_En, MEMWB_Bubble, Halted, StallCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush sequencer and HALT drain for the 5-stage pipeline.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               halted_q, halted_d;

    logic w_pc_we, w_ifid_en, w_ifid_fl, w_idex_en, w_idex_fl;
    logic w_exmem_en, w_memwb_en, w_memwb_bub;
    logic w_load_use, w_stall_inc;

    assign w_load_use = hz.IDEX_MemRead &
                        ((hz.IFID_RsValid & (hz.IFID_Rs == hz.IDEX_WR)) |
                         (hz.IFID_RtValid & (hz.IFID_Rt == hz.IDEX_WR)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        w_pc_we     = 1'b1;
        w_ifid_en   = 1'b1;
        w_ifid_fl   = 1'b0;
        w_idex_en   = 1'b1;
        w_idex_fl   = 1'b0;
        w_exmem_en  = 1'b1;
        w_memwb_en  = 1'b1;
        w_memwb_bub = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.DMemStall) begin
                    // Whole pipe freezes; WB is bubbled so a write is not repeated.
                    w_pc_we = 1'b0; w_ifid_en = 1'b0; w_idex_en = 1'b0;
                    w_exmem_en = 1'b0; w_memwb_en = 1'b0; w_memwb_bub = 1'b1;
                end else if (hz.BranchTaken_EX) begin
                    w_ifid_fl = 1'b1;
                    w_idex_fl = 1'b1;
                end else begin
                    if (w_load_use) begin
                        w_pc_we = 1'b0; w_ifid_en = 1'b0; w_idex_fl = 1'b1;
                    end else if (hz.IMemStall) begin
                        w_pc_we = 1'b0; w_ifid_fl = 1'b1;
                    end
                    if (hz.Halt_EX) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (hz.DMemStall) begin
                    w_pc_we = 1'b0; w_ifid_en = 1'b0; w_idex_en = 1'b0;
                    w_exmem_en = 1'b0; w_memwb_en = 1'b0; w_memwb_bub = 1'b1;
                end else begin
                    w_pc_we = 1'b0; w_ifid_fl = 1'b1; w_idex_fl = 1'b1;
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            default: begin
                w_pc_we = 1'b0; w_ifid_en = 1'b0; w_idex_en = 1'b0;
                w_exmem_en = 1'b0; w_memwb_en = 1'b0; w_memwb_bub = 1'b1;
            end
        endcase
    end

    assign w_stall_inc = (state_q != ST_HALTED) & (~w_pc_we | hz.DMemStall);
    assign stall_cnt_d = (w_stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
                         ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign halted_d    = (state_d == ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign hz.PCWrite_En   = w_pc_we;
    assign hz.IFID_En      = w_ifid_en;
    assign hz.IFID_Flush   = w_ifid_fl;
    assign hz.IDEX_En      = w_idex_en;
    assign hz.IDEX_Flush   = w_idex_fl;
    assign hz.EXMEM_En     = w_exmem_en;
    assign hz.MEMWB_En     = w_memwb_en;
    assign hz.MEMWB_Bubble = w_memwb_bub;
    assign hz.Halted       = halted_q;
    assign hz.StallCnt     = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed and random stimulus for hazard_ctrl against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // Control vector order: PCWrite, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush,
    // EXMEM_En, MEMWB_En, MEMWB_Bubble.
    localparam logic [7:0] V_NORMAL = 8'b1101_0110;
    localparam logic [7:0] V_SQUASH = 8'b1111_1110;
    localparam logic [7:0] V_LDUSE  = 8'b0001_1110;
    localparam logic [7:0] V_IMEM   = 8'b0111_0110;
    localparam logic [7:0] V_DRAIN  = 8'b0111_1110;
    localparam logic [7:0] V_FROZEN = 8'b0000_0001;

    typedef struct packed {
        logic       rst;
        logic       memrd;
        logic [2:0] wr;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rsv;
        logic       rtv;
        logic       br;
        logic       halt;
        logic       imem;
        logic       dmem;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = running, 1 = draining, 2 = halted.
    int m_mode    = 0;
    int m_drained = 0;
    int m_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_ctrl(input int mode, input stim_t s);
        logic lu;
        lu = s.memrd && ((s.rsv && s.rs == s.wr) || (s.rtv && s.rt == s.wr));
        if (mode == 2)  return V_FROZEN;
        if (s.dmem)     return V_FROZEN;
        if (mode == 1)  return V_DRAIN;
        if (s.br)       return V_SQUASH;
        if (lu)         return V_LDUSE;
        if (s.imem)     return V_IMEM;
        return V_NORMAL;
    endfunction

    function automatic logic [7:0] obs_ctrl();
        return {bus.PCWrite_En, bus.IFID_En, bus.IFID_Flush, bus.IDEX_En,
                bus.IDEX_Flush, bus.EXMEM_En, bus.MEMWB_En, bus.MEMWB_Bubble};
    endfunction

    task automatic apply(input stim_t s);
        rst                = s.rst;
        bus.IDEX_MemRead   = s.memrd;
        bus.IDEX_WR        = s.wr;
        bus.IFID_Rs        = s.rs;
        bus.IFID_Rt        = s.rt;
        bus.IFID_RsValid   = s.rsv;
        bus.IFID_RtValid   = s.rtv;
        bus.BranchTaken_EX = s.br;
        bus.Halt_EX        = s.halt;
        bus.IMemStall      = s.imem;
        bus.DMemStall      = s.dmem;
    endtask

    task automatic model_update(input stim_t s);
        logic [7:0] e;
        if (s.rst) begin
            m_mode = 0; m_drained = 0; m_cnt = 0;
        end else begin
            e = exp_ctrl(m_mode, s);
            if (m_mode != 2 && (!e[7] || s.dmem) && m_cnt < CNT_MAX) m_cnt++;
            if (m_mode == 0) begin
                if (!s.dmem && !s.br && s.halt) begin
                    m_mode = 1; m_drained = 0;
                end
            end else if (m_mode == 1) begin
                if (!s.dmem) begin
                    m_drained++;
                    if (m_drained == DRAIN_CYCLES) m_mode = 2;
                end
            end
        end
    endtask

    // Drive one cycle, check mid-cycle, advance the model at the clock edge.
    task automatic step(input stim_t s);
        apply(s);
        @(negedge clk);
        check("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(m_mode, s)));
        check("halted", 32'(bus.Halted), (m_mode == 2) ? 32'd1 : 32'd0);
        check("stallcnt", 32'(bus.StallCnt), 32'(m_cnt));
        @(posedge clk);
        model_update(s);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 59) == 0);
        s.memrd = ($urandom_range(0, 2) == 0);
        s.wr    = 3'($urandom_range(0, 3));
        s.rs    = 3'($urandom_range(0, 3));
        s.rt    = 3'($urandom_range(0, 3));
        s.rsv   = 1'($urandom_range(0, 1));
        s.rtv   = 1'($urandom_range(0, 1));
        s.br    = ($urandom_range(0, 5) == 0);
        s.halt  = ($urandom_range(0, 24) == 0);
        s.imem  = ($urandom_range(0, 4) == 0);
        s.dmem  = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    stim_t s, r;

    initial begin
        r = idle(); r.rst = 1'b1;
        apply(r);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(idle());
        check("reset_cnt", 32'(bus.StallCnt), 32'd0);

        // Load-use on Rs
        s = idle(); s.memrd = 1'b1; s.wr = 3'd3; s.rs = 3'd3; s.rsv = 1'b1;
        step(s);
        check("lu_cnt", 32'(bus.StallCnt), 32'd1);
        step(idle());

        // Branch hides load-use and IMemStall
        s.br = 1'b1; s.imem = 1'b1;
        step(s);
        check("br_cnt", 32'(bus.StallCnt), 32'd1);

        // DMemStall dominates a branch for 4 cycles, then the flush lands
        s = idle(); s.br = 1'b1; s.dmem = 1'b1;
        repeat (4) step(s);
        check("dm_cnt", 32'(bus.StallCnt), 32'd5);
        s.dmem = 1'b0;
        step(s);

        // Halt with no stalls: three drain cycles then halted
        s = idle(); s.halt = 1'b1;
        step(s);
        repeat (DRAIN_CYCLES) step(idle());
        check("halt_on_time", 32'(bus.Halted), 32'd1);
        s = idle(); s.br = 1'b1; s.imem = 1'b1; s.halt = 1'b1;
        repeat (2) step(s);
        r = idle(); r.rst = 1'b1;
        step(r);

        // Halt with a 2-cycle DMemStall inside the drain
        s = idle(); s.halt = 1'b1;
        step(s);
        step(idle());
        s = idle(); s.dmem = 1'b1;
        repeat (2) step(s);
        step(idle());
        check("halt_delayed", 32'(bus.Halted), 32'd0);
        step(idle());
        check("halt_late", 32'(bus.Halted), 32'd1);
        step(idle());
        step(r);

        // Reset in mid-drain
        s = idle(); s.halt = 1'b1;
        step(s);
        step(idle());
        step(r);
        apply(idle());
        #1;
        check("rst_drain_halted", 32'(bus.Halted), 32'd0);
        check("rst_drain_cnt", 32'(bus.StallCnt), 32'd0);
        check("rst_drain_ctrl", 32'(obs_ctrl()), 32'(V_NORMAL));
        step(idle());

        // Random mix
        for (int i = 0; i < 3000; i++) step(rand_stim());

        // Counter saturation
        step(r);
        s = idle(); s.imem = 1'b1;
        for (int i = 0; i < CNT_MAX + 5; i++) step(s);
        check("sat", 32'(bus.StallCnt), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
